dct_block_sched: RTL and testbench
==================================

Name: dct_block_sched

Overview:
- Sequencer for the 8-point DCT zone datapath: the eight dct_zN units, each with ROM1/ROM2 coefficient ROMs.
- Frames the incoming 8-bit EEG sample stream into 8-sample blocks and drives the zone units' en/cs for the fixed compute window.
- Captures the eight 19-bit coefficients and streams them in zone order to the downstream RLE stage over valid/ready.
- Sits between the sample source and the dct_z0..dct_z7 bank / RLE encoder in the DCT+RLE top.

Parameters:
- N, 8, samples per block and coefficients per block; fixed at 8, the index widths depend on it.
- IW, 8, sample width (signed).
- CW, 19, coefficient width (signed; matches the zone OUTPUT width).
- DCT_LAT, 9, cycles en/cs are held high per block; coefficients are valid at the end of the last cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  sample valid.
- s_data  in  IW  signed EEG sample.
- s_ready  out  1  sample accept.
- blk_data  out  N*IW  packed block to the zone inputs; [IW-1:0]=input0 … [N*IW-1:(N-1)*IW]=input7.
- dct_en  out  1  en to all zone units.
- dct_cs  out  1  cs to all zone ROMs.
- coef_in  in  N*CW  packed zone outputs; [CW-1:0]=OUTPUT_Z0 … top slice=OUTPUT_Z7.
- m_valid  out  1  coefficient valid.
- m_data  out  CW  signed coefficient.
- m_idx  out  3  zone index of m_data (0..7).
- m_last  out  1  high with idx 7.
- m_ready  in  1  downstream accept.
- busy  out  1  high when the FSM is not in FILL or the sample count is nonzero.

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-high.
- All state is registered. rst asserted clears:
  - FSM to FILL, sample count and coefficient index to 0.
  - blk_data, coefficient buffer and run counter to 0.
  - dct_en, dct_cs, m_valid, m_last, busy to 0.
- s_ready is gated to 0 while rst is high and is 1 in FILL from the first cycle after release.
- FILL:
  - s_ready=1. Each s_valid&s_ready writes s_data into slot cnt, then cnt++.
  - The handshake at cnt=7 moves to RUN next cycle; cnt wraps to 0.
- RUN:
  - s_ready=0; dct_en=dct_cs=1 for exactly DCT_LAT consecutive cycles; blk_data held stable.
  - At the edge ending the last RUN cycle, coef_in is latched into an 8×CW buffer and the FSM enters DRAIN.
  - dct_en/cs drop to 0 in the DRAIN cycle.
- DRAIN:
  - m_valid=1, m_data=buf[idx], m_idx=idx, m_last=(idx==7).
  - On m_valid&m_ready, idx++. The handshake at idx=7 goes to FILL and idx wraps to 0.
  - With m_ready low, m_data/m_idx/m_last are held stable and m_valid stays high.
- Latency: last sample accepted at edge T → dct_en high over cycles T+1..T+DCT_LAT → m_valid rises at T+DCT_LAT+1. With m_ready tied high, coefficient k is transferred at edge T+DCT_LAT+1+k.
- Throughput without the optional feature: one block per 8 + DCT_LAT + 8 cycles minimum.
- s_valid while s_ready=0 is ignored; the source must hold.
- Reset mid-block, in any state, discards partial samples and coefficients. No output handshake occurs during or after the reset edge.
- coef_in is sampled only at the capture edge; changes at any other time have no effect.

Optional Feature:
- Macro: DCT_SCHED_OVERLAP_FILL_EN.
- Defined:
  - s_ready is also 1 in DRAIN, and samples of the next block load into blk_data. This is safe because the zone units are idle in DRAIN.
  - On the idx=7 handshake: if cnt has already wrapped (8 samples held, flag full=1), go directly to RUN. Otherwise go to FILL and continue at cnt.
  - If the 8th sample handshake and the idx=7 handshake occur in the same cycle, go to RUN.
  - Once full=1, s_ready=0 until RUN.
- Undefined: s_ready is 0 outside FILL; no full flag is generated.

Test Plan:
- Reset then samples 1..8 back-to-back, m_ready=1, coef_in slices = 100,-200,…,800 → blk_data=0x0807060504030201; dct_en high exactly 9 cycles; m_data sequence 100,-200,…,800 with idx 0..7 and m_last on idx 7 only.
- Same block with m_ready toggling 1,0,0,1… → no coefficient lost or repeated; m_data stable while m_ready=0; exactly 8 transfers.
- s_valid high during RUN with data 0x7F → no acceptance, blk_data unchanged; block's 9th sample accepted only after m_last handshake.
- Assert rst for 1 cycle after 5 samples, then send 8 fresh samples → output reflects only the fresh block; dct_en=0 throughout reset.
- coef_in = -262144 (min 19-bit) on all zones → m_data=0x40000 each, sign preserved.
- With DCT_SCHED_OVERLAP_FILL_EN: stream 16 samples continuously, m_ready=1 → second RUN begins the cycle after first m_last handshake; zero idle cycles of s_ready in DRAIN.

Source files
------------

// File: rtl/dct_block_sched_if.sv
// Bus bundle between the DCT block scheduler and its neighbours: sample stream in,
// block/enable to the zone bank, coefficients back, and the coefficient stream out.
interface dct_block_sched_if #(
   parameter int N  = 8,
   parameter int IW = 8,
   parameter int CW = 19
);
   logic                 s_valid;
   logic signed [IW-1:0] s_data;
   logic                 s_ready;
   logic [N*IW-1:0]      blk_data;
   logic                 dct_en;
   logic                 dct_cs;
   logic [N*CW-1:0]      coef_in;
   logic                 m_valid;
   logic signed [CW-1:0] m_data;
   logic [2:0]           m_idx;
   logic                 m_last;
   logic                 m_ready;
   logic                 busy;

   // master: the scheduler; slave: sample source, zone bank and RLE stage
   modport master (
      input  s_valid, s_data, coef_in, m_ready,
      output s_ready, blk_data, dct_en, dct_cs, m_valid, m_data, m_idx, m_last, busy
   );
   modport slave (
      output s_valid, s_data, coef_in, m_ready,
      input  s_ready, blk_data, dct_en, dct_cs, m_valid, m_data, m_idx, m_last, busy
   );
endinterface

// File: rtl/dct_block_sched.sv
// Frames 8-sample blocks, runs the dct_z0..7 bank for DCT_LAT cycles and drains the coefficients.
// Optional macro DCT_SCHED_OVERLAP_FILL_EN: accept the next block's samples while draining.
module dct_block_sched #(
   parameter int N       = 8,
   parameter int IW      = 8,
   parameter int CW      = 19,
   parameter int DCT_LAT = 9
) (
   input  logic             clk,
   input  logic             rst,
   dct_block_sched_if.master bus
);
   localparam int RW = $clog2(DCT_LAT + 1);

   typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

   state_t               r_state, w_state_next;
   logic [2:0]           r_cnt, w_cnt_next;
   logic [2:0]           r_idx, w_idx_next;
   logic [RW-1:0]        r_run, w_run_next;
   logic signed [IW-1:0] r_slot [N];
   logic signed [CW-1:0] r_buf  [N];
   logic                 w_s_ready;
   logic                 w_s_fire;
   logic                 w_m_fire;
   logic                 w_capture;
   logic                 w_last_sample;

`ifdef DCT_SCHED_OVERLAP_FILL_EN
   logic r_full, w_full_next;
`endif

   always_comb begin
`ifdef DCT_SCHED_OVERLAP_FILL_EN
      w_s_ready = ~rst & ~r_full & ((r_state == FILL) | (r_state == DRAIN));
`else
      w_s_ready = ~rst & (r_state == FILL);
`endif
      w_s_fire      = bus.s_valid & w_s_ready;
      w_m_fire      = (r_state == DRAIN) & bus.m_ready;
      w_last_sample = w_s_fire & (r_cnt == 3'(N - 1));
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = w_s_fire ? r_cnt + 3'd1 : r_cnt;
      w_idx_next   = r_idx;
      w_run_next   = '0;
      w_capture    = 1'b0;
      case (r_state)
         FILL: begin
            if (w_last_sample) w_state_next = RUN;
         end
         RUN: begin
            if (r_run == RW'(DCT_LAT - 1)) begin
               w_state_next = DRAIN;
               w_capture    = 1'b1;
            end else begin
               w_run_next = r_run + RW'(1);
            end
         end
         DRAIN: begin
            if (w_m_fire) begin
               w_idx_next = r_idx + 3'd1;
               if (r_idx == 3'(N - 1)) begin
`ifdef DCT_SCHED_OVERLAP_FILL_EN
                  // A block completed during (or exactly at the end of) the drain starts at once
                  w_state_next = (r_full | w_last_sample) ? RUN : FILL;
`else
                  w_state_next = FILL;
`endif
               end
            end
         end
         default: w_state_next = FILL;
      endcase
`ifdef DCT_SCHED_OVERLAP_FILL_EN
      if (w_state_next == RUN)  w_full_next = 1'b0;
      else if (w_last_sample)   w_full_next = 1'b1;
      else                      w_full_next = r_full;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FILL;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_run   <= '0;
`ifdef DCT_SCHED_OVERLAP_FILL_EN
         r_full  <= 1'b0;
`endif
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_idx   <= w_idx_next;
         r_run   <= w_run_next;
`ifdef DCT_SCHED_OVERLAP_FILL_EN
         r_full  <= w_full_next;
`endif
      end
   end

   // Sample slots load only on handshake; the coefficient buffer only on the capture edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            r_slot[k] <= '0;
            r_buf[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (w_s_fire && (r_cnt == 3'(k))) r_slot[k] <= bus.s_data;
            if (w_capture) r_buf[k] <= bus.coef_in[k*CW +: CW];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_blk
         assign bus.blk_data[gi*IW +: IW] = r_slot[gi];
      end
   endgenerate

   assign bus.s_ready = w_s_ready;
   assign bus.dct_en  = (r_state == RUN);
   assign bus.dct_cs  = (r_state == RUN);
   assign bus.m_valid = (r_state == DRAIN);
   assign bus.m_data  = r_buf[r_idx];
   assign bus.m_idx   = r_idx;
   assign bus.m_last  = (r_state == DRAIN) & (r_idx == 3'(N - 1));
   assign bus.busy    = (r_state != FILL) | (r_cnt != 3'd0);
endmodule

// File: tb/tb_dct_block_sched.sv
// Directed bench for dct_block_sched: framing, RUN window, drain with backpressure,
// mid-block reset, min coefficient, and (when built with the macro) overlapped fill.
module tb_dct_block_sched;
   localparam int N = 8, IW = 8, CW = 19, DCT_LAT = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dct_block_sched_if #(.N(N), .IW(IW), .CW(CW)) bus_if ();

   dct_block_sched #(.N(N), .IW(IW), .CW(CW), .DCT_LAT(DCT_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if.master)
   );

   int n_cmp = 0;
   int n_err = 0;

   int cset1[N] = '{100, -200, 300, -400, 500, -600, 700, 800};
   int cset2[N] = '{-1, 2, -3, 4, 65535, -65536, 131071, -131072};
   int cmin [N] = '{-262144, -262144, -262144, -262144, -262144, -262144, -262144, -262144};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_coefs(input int c[N]);
      for (int k = 0; k < N; k++) bus_if.coef_in[k*CW +: CW] = CW'(c[k]);
   endtask

   // Sends count samples first, first+1, ...; optionally keeps s_valid high with 0x7F afterwards
   task automatic send_samples(input logic [IW-1:0] first, input int count, input logic hold7f);
      int   waited;
      logic acc;
      for (int i = 0; i < count; i++) begin
         waited = 0;
         acc    = 1'b0;
         bus_if.s_valid = 1'b1;
         bus_if.s_data  = first + IW'(i);
         while (!acc && waited < 40) begin
            @(negedge clk);
            acc = bus_if.s_ready;
            @(posedge clk);
            #1;
            waited++;
         end
         if (!acc) check("s_accept_timeout", 64'(acc), 64'd1);
      end
      bus_if.s_valid = hold7f;
      bus_if.s_data  = hold7f ? 8'h7F : 8'h00;
   endtask

   // Called right after the edge accepting the 8th sample
   task automatic expect_run(input logic [N*IW-1:0] exp_blk);
      for (int c = 0; c < DCT_LAT; c++) begin
         @(negedge clk);
         check("run_dct_en", 64'(bus_if.dct_en), 64'd1);
         check("run_dct_cs", 64'(bus_if.dct_cs), 64'd1);
         check("run_s_ready", 64'(bus_if.s_ready), 64'd0);
         check("run_m_valid", 64'(bus_if.m_valid), 64'd0);
         check("run_blk_data", 64'(bus_if.blk_data), 64'(exp_blk));
         @(posedge clk);
         #1;
      end
   endtask

   // mode 0: m_ready always high; mode 1: m_ready pattern 1,0,0,1,0,0,...
   task automatic drain(input int exp[N], input int mode);
      int xfer;
      int cyc;
      logic signed [CW-1:0] e;
      xfer = 0;
      cyc  = 0;
      bus_if.coef_in = ~bus_if.coef_in;
      while (xfer < N && cyc < 60) begin
         bus_if.m_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         @(negedge clk);
         e = CW'(exp[xfer]);
         check("drain_dct_en", 64'(bus_if.dct_en), 64'd0);
         check("drain_m_valid", 64'(bus_if.m_valid), 64'd1);
         check("drain_m_idx", 64'(bus_if.m_idx), 64'(xfer));
         check("drain_m_data", 64'(bus_if.m_data), 64'(e));
         check("drain_m_last", 64'(bus_if.m_last), 64'(xfer == N - 1));
`ifndef DCT_SCHED_OVERLAP_FILL_EN
         check("drain_s_ready", 64'(bus_if.s_ready), 64'd0);
`endif
         if (bus_if.m_valid && bus_if.m_ready) begin
            $display("xfer idx=%0d data=%0d last=%0d", bus_if.m_idx, bus_if.m_data, bus_if.m_last);
            xfer++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      check("drain_xfer_count", 64'(xfer), 64'(N));
      bus_if.m_ready = 1'b0;
   endtask

   initial begin
      bus_if.s_valid = 1'b0;
      bus_if.s_data  = '0;
      bus_if.m_ready = 1'b0;
      bus_if.coef_in = '0;

      // Reset state
      @(negedge clk);
      check("rst_s_ready", 64'(bus_if.s_ready), 64'd0);
      check("rst_dct_en", 64'(bus_if.dct_en), 64'd0);
      check("rst_m_valid", 64'(bus_if.m_valid), 64'd0);
      check("rst_busy", 64'(bus_if.busy), 64'd0);
      check("rst_blk_data", 64'(bus_if.blk_data), 64'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_s_ready", 64'(bus_if.s_ready), 64'd1);
      step();

      // Block 1: samples 1..8, m_ready high
      set_coefs(cset1);
      send_samples(8'h01, 8, 1'b0);
      check("blk1_busy", 64'(bus_if.busy), 64'd1);
      expect_run(64'h0807060504030201);
      drain(cset1, 0);
      @(negedge clk);
      check("blk1_idle_m_valid", 64'(bus_if.m_valid), 64'd0);
      check("blk1_idle_busy", 64'(bus_if.busy), 64'd0);
      step();

      // Block 2: same block, toggling m_ready
      set_coefs(cset2);
      send_samples(8'h01, 8, 1'b0);
      expect_run(64'h0807060504030201);
      drain(cset2, 1);
      step();

`ifndef DCT_SCHED_OVERLAP_FILL_EN
      // Block 3: s_valid held with 0x7F through RUN and DRAIN
      set_coefs(cset1);
      send_samples(8'h31, 8, 1'b1);
      expect_run(64'h3837363534333231);
      drain(cset1, 0);
      @(negedge clk);
      check("hold_s_ready_fill", 64'(bus_if.s_ready), 64'd1);
      step();
      check("hold_blk_slot0", 64'(bus_if.blk_data), 64'h383736353433327F);
      check("hold_busy", 64'(bus_if.busy), 64'd1);
      bus_if.s_valid = 1'b0;
      step();
`endif

      // Mid-block reset after 5 samples, then a fresh block
      send_samples(8'h11, 5, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_s_ready", 64'(bus_if.s_ready), 64'd0);
      check("mid_rst_dct_en", 64'(bus_if.dct_en), 64'd0);
      check("mid_rst_blk_data", 64'(bus_if.blk_data), 64'd0);
      check("mid_rst_busy", 64'(bus_if.busy), 64'd0);
      step();
      @(negedge clk);
      check("mid_rst_dct_en2", 64'(bus_if.dct_en), 64'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("mid_rel_s_ready", 64'(bus_if.s_ready), 64'd1);
      check("mid_rel_m_valid", 64'(bus_if.m_valid), 64'd0);
      step();
      set_coefs(cset2);
      send_samples(8'hA1, 8, 1'b0);
      expect_run(64'hA8A7A6A5A4A3A2A1);
      drain(cset2, 0);
      step();

      // Minimum 19-bit coefficient on every zone
      set_coefs(cmin);
      send_samples(8'hF9, 8, 1'b0);
      expect_run(64'h0000FFFEFDFCFBFAF9 >> 0);
      drain(cmin, 0);
      step();

`ifdef DCT_SCHED_OVERLAP_FILL_EN
      begin
         int   acc;
         int   c;
         int   last_cyc;
         logic done;
         acc      = 0;
         c        = 0;
         last_cyc = -1;
         done     = 1'b0;
         set_coefs(cset1);
         bus_if.m_ready = 1'b1;
         while (c < 80 && !done) begin
            bus_if.s_valid = (acc < 16);
            bus_if.s_data  = IW'(acc + 1);
            @(negedge clk);
            if (bus_if.m_valid && acc < 16) check("ovl_s_ready_drain", 64'(bus_if.s_ready), 64'd1);
            if (last_cyc >= 0 && last_cyc == c - 1) begin
               check("ovl_run2_start", 64'(bus_if.dct_en), 64'd1);
               check("ovl_blk2", 64'(bus_if.blk_data), 64'h100F0E0D0C0B0A09);
               done = 1'b1;
            end
            if (bus_if.m_valid && bus_if.m_ready && bus_if.m_last && last_cyc < 0) last_cyc = c;
            if (bus_if.s_valid && bus_if.s_ready) acc++;
            @(posedge clk);
            #1;
            c++;
         end
         check("ovl_done", 64'(done), 64'd1);
         check("ovl_accepted", 64'(acc), 64'd16);
         bus_if.s_valid = 1'b0;
         bus_if.m_ready = 1'b0;
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
